encoder_8_3_seq: RTL

// - Sequential inverse of the 3-to-8 decoder: captures an 8-bit request vector
//   and emits the index of every set bit, one per accepted transfer.
// - Emission order is selectable (lowest or highest bit first).
// - Output is a registered valid/ready stream; its indices can drive a

---
 rtl/encoder_8_3_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/encoder_8_3_seq.sv
// Sequential priority encoder: loads a request vector and streams
// the index of each set bit over a registered valid/ready output.
module encoder_8_3_seq #(
  parameter int WIDTH     = 8,
  parameter int IDXW      = 3,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                       clka,
  input  logic                       rst,
  input  logic                       E,
  input  logic [WIDTH-1:0]           In,
  input  logic                       Rdy,
  output logic [IDXW-1:0]            Out,
  output logic                       V,
  output logic                       Busy,
  output logic [$clog2(WIDTH+1)-1:0] Cnt
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] pend_q, pend_n;
  logic [IDXW-1:0]  out_q, out_n;
  logic             v_q, v_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] nxt;
  logic             accept;
  logic             load;

  function automatic logic [IDXW-1:0] enc(
    input logic [WIDTH-1:0] vec
  );
    logic [IDXW-1:0] r;
    r = '0;
    if (LOW_FIRST) begin
      for (int i = WIDTH-1; i >= 0; i--)
        if (vec[i]) r = IDXW'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (vec[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] popcnt(
    input logic [WIDTH-1:0] vec
  );
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      r = r + CW'(vec[i]);
    return r;
  endfunction

  always_comb begin
    state_n = state_q;
    pend_n  = pend_q;
    out_n   = out_q;
    v_n     = v_q;
    cnt_n   = cnt_q;
    load    = 1'b0;
    nxt     = pend_q & ~(WIDTH'(1) << out_q);
    accept  = v_q && Rdy;
    // a new vector is taken only when nothing is left after this edge
    unique case (state_q)
      IDLE:    load = E && (In != '0);
      DRAIN:   load = E && (In != '0) && accept
                      && (nxt == '0);
      default: load = 1'b0;
    endcase
    if (load) begin
      pend_n  = In;
      out_n   = enc(In);
      v_n     = 1'b1;
      cnt_n   = popcnt(In);
      state_n = DRAIN;
    end else if (accept) begin
      pend_n  = nxt;
      out_n   = enc(nxt);
      v_n     = nxt != '0;
      cnt_n   = cnt_q - CW'(1);
      state_n = (nxt != '0) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      out_q   <= '0;
      v_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pend_q  <= pend_n;
      out_q   <= out_n;
      v_q     <= v_n;
      cnt_q   <= cnt_n;
    end
  end

  assign Out  = out_q;
  assign V    = v_q;
  assign Busy = v_q;
  assign Cnt  = cnt_q;

endmodule
